// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pops async_fifo read port into a 2-entry buffer, presents a valid/ready stream (o_count = occupancy, o_pop_cnt = pops issued)
module fifo_rd_stream #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_empty,
    output logic             o_pop,
    input  logic [WIDTH-1:0] i_rdata,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready,
    output logic [1:0]       o_count,
    output logic [CNT_W-1:0] o_pop_cnt
);
    logic [1:0]       count, count_n;
    logic             inflight, accept, wr_head;
    logic [2:0]       occ;
    logic [WIDTH-1:0] head, tail, head_n, tail_n;
    always_comb begin
        accept  = (count != 2'd0) & i_ready;
        occ     = {1'b0, count} + {2'b0, inflight};
        o_pop   = !i_rst & !i_empty & ((occ < 3'd2) | ((occ == 3'd2) & accept));
        wr_head = inflight & ((count == 2'd0) | ((count == 2'd1) & accept));
        head_n  = wr_head ? i_rdata : accept ? tail : head;
        tail_n  = (inflight & !wr_head) ? i_rdata : tail;
        count_n = count + {1'b0, inflight} - {1'b0, accept};
    end
    assign o_valid = count != 2'd0;
    assign o_data  = head;
    assign o_count = count;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count     <= '0;
            inflight  <= 1'b0;
            head      <= '0;
            tail      <= '0;
            o_pop_cnt <= '0;
        end else begin
            count     <= count_n;
            inflight  <= o_pop;
            head      <= head_n;
            tail      <= tail_n;
            o_pop_cnt <= o_pop_cnt + {{(CNT_W-1){1'b0}}, o_pop};
        end
    end
endmodule
